// File: rtl/bus_memory_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_memory_interface_pkg
// Brief   : Shared definitions for the Bat Amateur bus-to-memory bridge.
//           Holds the FSM state encoding (IDLE=0, REQ=1, DONE=2) and the
//           RW direction constants. The control sequencer uses the same
//           values, so change them in both places or not at all.
// Revision: 1.0 - initial release
// ============================================================================
package bus_memory_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bmi_state_t;

    // RW=1 puts memory data on the bus, RW=0 takes bus data into memory.
    localparam logic c_RW_READ  = 1'b1;
    localparam logic c_RW_WRITE = 1'b0;

endpackage : bus_memory_interface_pkg
`default_nettype wire

// File: rtl/bus_memory_interface_mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : mem_timeout_counter
// Brief   : Wait-state counter for the memory handshake. Cleared when a
//           request starts, counts while enabled, and flags the last
//           permitted REQ cycle so the FSM can give up on that edge.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous reset, active low
//           i_clear    - restart count at zero (entry to REQ)
//           i_enable   - count this cycle (FSM in REQ)
//           o_terminal - high in the TIMEOUT-th cycle after clear
// Revision: 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    // The count equals the number of REQ cycles already completed, so the
    // terminal flag rises during the TIMEOUT-th REQ cycle and the FSM leaves
    // REQ on the edge that ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == c_LAST);

endmodule : mem_timeout_counter
`default_nettype wire

// File: rtl/bus_memory_interface.sv
`default_nettype none
// ============================================================================
// Module  : bus_memory_interface
// Brief   : Bridges the shared DATA bus to an external synchronous memory
//           with a REQ/ACK handshake and variable wait states. READY pulses
//           for one cycle when the access completes.
// Config  : MEM_TIMEOUT_EN - when defined, a REQ that sees no ACK within
//           TIMEOUT cycles completes with ERROR=1 and all-ones read data.
//           When undefined, REQ waits forever and ERROR is tied low.
// Ports   : CLOCK, RESET (async, active low)
//           RW, ENABLE, ADDR      - bus-side request from the sequencer/MAR
//           DATA (inout)          - shared bus, driven only for reads in DONE
//           READY, ERROR          - completion pulse / sticky timeout flag
//           MEM_ADDR, MEM_WDATA, MEM_REQ, MEM_WE  - memory request side
//           MEM_RDATA, MEM_ACK                    - memory response side
// Revision: 1.0 - initial release
// ============================================================================
module bus_memory_interface
    import bus_memory_interface_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  RW,
    input  logic                  ENABLE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    inout  wire  [BUS_WIDTH-1:0]  DATA,
    output logic                  READY,
    output logic                  ERROR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [BUS_WIDTH-1:0]  MEM_WDATA,
    input  logic [BUS_WIDTH-1:0]  MEM_RDATA,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    input  logic                  MEM_ACK
);

    bmi_state_t            r_state;
    bmi_state_t            w_state_next;
    logic                  r_armed;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0]  r_wdata;
    logic [BUS_WIDTH-1:0]  r_rdata;
    logic                  w_start;
    logic                  w_in_req;
    logic                  w_timeout;
    logic                  w_drive;

    assign w_in_req = (r_state == ST_REQ);
    // ARMED makes a held-high ENABLE good for one access only.
    assign w_start  = (r_state == ST_IDLE) && ENABLE && r_armed;

`ifdef MEM_TIMEOUT_EN
    logic w_terminal;
    logic r_error;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (CLOCK),
        .rst_n      (RESET),
        .i_clear    (w_start),
        .i_enable   (w_in_req),
        .o_terminal (w_terminal)
    );

    // An ACK arriving in the last permitted cycle still wins over the timeout.
    assign w_timeout = w_in_req && w_terminal && !MEM_ACK;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_error <= 1'b0;
        end else if (w_start) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign ERROR = r_error;
`else
    assign w_timeout = 1'b0;
    assign ERROR     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)              w_state_next = ST_REQ;
            ST_REQ:  if (MEM_ACK || w_timeout) w_state_next = ST_DONE;
            ST_DONE:                           w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches and read capture
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_armed <= 1'b1;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_armed <= 1'b0;
            end else if (!ENABLE) begin
                r_armed <= 1'b1;
            end

            if (w_start) begin
                r_addr <= ADDR;
                r_rw   <= RW;
                if (RW == c_RW_WRITE) begin
                    r_wdata <= DATA;
                end
            end

            if (w_in_req && (r_rw == c_RW_READ)) begin
                if (MEM_ACK) begin
                    r_rdata <= MEM_RDATA;
                end else if (w_timeout) begin
                    r_rdata <= '1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MEM_REQ   = w_in_req;
    assign MEM_WE    = w_in_req && (r_rw == c_RW_WRITE);
    assign MEM_ADDR  = r_addr;
    assign MEM_WDATA = r_wdata;
    assign READY     = (r_state == ST_DONE);

    // The bus is only ours while the sequencer still asks for the read.
    assign w_drive = (r_state == ST_DONE) && (r_rw == c_RW_READ) && ENABLE;
    assign DATA    = w_drive ? r_rdata : {BUS_WIDTH{1'bz}};

endmodule : bus_memory_interface
`default_nettype wire

// File: tb/tb_bus_memory_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_memory_interface
// Brief   : Directed self-checking bench for bus_memory_interface.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_memory_interface;

    logic        CLOCK;
    logic        RESET;
    logic        RW;
    logic        ENABLE;
    logic [15:0] ADDR;
    wire  [15:0] DATA;
    logic        READY;
    logic        ERROR;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic        MEM_ACK;

    logic        tb_oe;
    logic [15:0] tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    assign DATA = tb_oe ? tb_val : 16'hzzzz;

    bus_memory_interface #(
        .BUS_WIDTH  (16),
        .ADDR_WIDTH (16),
        .TIMEOUT    (4)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .RW        (RW),
        .ENABLE    (ENABLE),
        .ADDR      (ADDR),
        .DATA      (DATA),
        .READY     (READY),
        .ERROR     (ERROR),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ACK   (MEM_ACK)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        RESET     = 1'b0;
        RW        = 1'b0;
        ENABLE    = 1'b0;
        ADDR      = 16'h0000;
        MEM_RDATA = 16'h0000;
        MEM_ACK   = 1'b0;
        tb_oe     = 1'b0;
        tb_val    = 16'h0000;

        // ---------------- reset state ----------------
        #2;
        check("rst_mem_req",   32'(MEM_REQ),   32'h0);
        check("rst_mem_we",    32'(MEM_WE),    32'h0);
        check("rst_ready",     32'(READY),     32'h0);
        check("rst_error",     32'(ERROR),     32'h0);
        check("rst_mem_addr",  32'(MEM_ADDR),  32'h0);
        check("rst_mem_wdata", 32'(MEM_WDATA), 32'h0);
        tick();
        tick();
        RESET = 1'b1;
        tick();

        // ---------------- read, zero wait states ----------------
        // ACK already high while IDLE: must be ignored until REQ.
        ADDR = 16'h0010; RW = 1'b1; ENABLE = 1'b1;
        MEM_RDATA = 16'hBEEF; MEM_ACK = 1'b1;
        tick();
        check("r0_req",   32'(MEM_REQ),  32'h1);
        check("r0_we",    32'(MEM_WE),   32'h0);
        check("r0_addr",  32'(MEM_ADDR), 32'h0010);
        check("r0_ready", 32'(READY),    32'h0);
        tick();
        check("r0_done_ready", 32'(READY),   32'h1);
        check("r0_done_req",   32'(MEM_REQ), 32'h0);
        check("r0_bus",        32'(DATA),    32'hBEEF);
        MEM_ACK = 1'b0; ENABLE = 1'b0;
        tick();
        check("r0_idle_ready", 32'(READY), 32'h0);

        // ---------------- read, three wait states ----------------
        ADDR = 16'h0020; RW = 1'b1; ENABLE = 1'b1; MEM_RDATA = 16'hCAFE;
        tick();
        ADDR = 16'hFFFF;   // latched address must not follow the input
        for (int i = 0; i < 3; i++) begin
            check("r3_req",   32'(MEM_REQ),  32'h1);
            check("r3_addr",  32'(MEM_ADDR), 32'h0020);
            check("r3_ready", 32'(READY),    32'h0);
            tick();
        end
        MEM_ACK = 1'b1;
        check("r3_req4",  32'(MEM_REQ),  32'h1);
        check("r3_addr4", 32'(MEM_ADDR), 32'h0020);
        tick();
        check("r3_ready", 32'(READY), 32'h1);
        check("r3_bus",   32'(DATA),  32'hCAFE);
        MEM_ACK = 1'b0;

        // ---------------- ENABLE held high: no second access ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_no_req",   32'(MEM_REQ), 32'h0);
            check("hold_no_ready", 32'(READY),   32'h0);
        end

        // ---------------- drop ENABLE one cycle, then write ----------------
        ENABLE = 1'b0;
        tick();
        ENABLE = 1'b1; RW = 1'b0; ADDR = 16'h00FF;
        tb_oe = 1'b1; tb_val = 16'h1234;
        tick();
        check("wr_req",   32'(MEM_REQ),   32'h1);
        check("wr_we",    32'(MEM_WE),    32'h1);
        check("wr_addr",  32'(MEM_ADDR),  32'h00FF);
        check("wr_wdata", 32'(MEM_WDATA), 32'h1234);
        check("wr_bus",   32'(DATA),      32'h1234);
        tb_val = 16'h5A5A;   // any DUT drive would corrupt this value
        MEM_ACK = 1'b1;
        tick();
        check("wr_ready",     32'(READY),     32'h1);
        check("wr_we_done",   32'(MEM_WE),    32'h0);
        check("wr_bus_done",  32'(DATA),      32'h5A5A);
        check("wr_wdata_hld", 32'(MEM_WDATA), 32'h1234);
        MEM_ACK = 1'b0; ENABLE = 1'b0;
        tick();
        tb_oe = 1'b0;

        // ---------------- ENABLE dropped during REQ ----------------
        RW = 1'b1; ADDR = 16'h0030; ENABLE = 1'b1; MEM_RDATA = 16'h1111;
        tick();
        check("drop_req", 32'(MEM_REQ), 32'h1);
        ENABLE = 1'b0; tb_oe = 1'b1; tb_val = 16'h5A5A;
        tick();
        check("drop_req_held", 32'(MEM_REQ), 32'h1);
        MEM_ACK = 1'b1;
        tick();
        check("drop_ready", 32'(READY), 32'h1);
        check("drop_bus",   32'(DATA),  32'h5A5A);
        MEM_ACK = 1'b0;
        tick();
        tb_oe = 1'b0;

        // ---------------- reset in the middle of REQ ----------------
        RW = 1'b1; ADDR = 16'h0040; ENABLE = 1'b1;
        tick();
        check("mr_req", 32'(MEM_REQ), 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        check("mr_req_drop", 32'(MEM_REQ),  32'h0);
        check("mr_addr_clr", 32'(MEM_ADDR), 32'h0);
        MEM_ACK = 1'b1;
        tick();
        check("mr_no_ready", 32'(READY), 32'h0);
        MEM_ACK = 1'b0;
        RESET = 1'b1;
        ADDR = 16'h0050; MEM_RDATA = 16'h7777;
        tick();
        check("mr_next_req",  32'(MEM_REQ),  32'h1);
        check("mr_next_addr", 32'(MEM_ADDR), 32'h0050);
        MEM_ACK = 1'b1;
        tick();
        check("mr_next_ready", 32'(READY), 32'h1);
        check("mr_next_bus",   32'(DATA),  32'h7777);
        check("mr_next_error", 32'(ERROR), 32'h0);
        MEM_ACK = 1'b0; ENABLE = 1'b0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // ---------------- timeout after 4 REQ cycles ----------------
        RW = 1'b1; ADDR = 16'h0060; ENABLE = 1'b1; MEM_RDATA = 16'h0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_req",   32'(MEM_REQ), 32'h1);
            check("to_ready", 32'(READY),   32'h0);
            tick();
        end
        check("to_done_ready", 32'(READY), 32'h1);
        check("to_error",      32'(ERROR), 32'h1);
        check("to_bus",        32'(DATA),  32'hFFFF);
        ENABLE = 1'b0;
        tick();
        check("to_error_sticky", 32'(ERROR), 32'h1);
        ENABLE = 1'b1; MEM_RDATA = 16'h2222;
        tick();
        check("to_error_clr", 32'(ERROR),   32'h0);
        check("to_next_req",  32'(MEM_REQ), 32'h1);
        MEM_ACK = 1'b1;
        tick();
        check("to_next_bus",   32'(DATA),  32'h2222);
        check("to_next_error", 32'(ERROR), 32'h0);
        MEM_ACK = 1'b0; ENABLE = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_memory_interface
`default_nettype wire
